// File: rtl/rdma_sq_arbiter.sv
// Round-robin arbiter sharing one RDMA send queue among N_REQ requesters, with
// per-requester credit limits and index-steered completion acks on the return path.
module rdma_sq_arbiter #(
  parameter int N_REQ      = 4,
  parameter int SQ_BITS    = 256,
  parameter int ACK_BITS   = 32,
  parameter int ID_BITS    = 4,
  parameter int SQ_ID_LSB  = 0,
  parameter int ACK_ID_LSB = 0,
  parameter int MAX_OUT    = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [N_REQ-1:0]         s_sq_valid,
  output logic [N_REQ-1:0]         s_sq_ready,
  input  logic [N_REQ*SQ_BITS-1:0] s_sq_data,
  output logic                     m_sq_valid,
  input  logic                     m_sq_ready,
  output logic [SQ_BITS-1:0]       m_sq_data,
  input  logic                     s_cq_valid,
  output logic                     s_cq_ready,
  input  logic [ACK_BITS-1:0]      s_cq_data,
  output logic [N_REQ-1:0]         m_cq_valid,
  input  logic [N_REQ-1:0]         m_cq_ready,
  output logic [ACK_BITS-1:0]      m_cq_data,
  output logic [N_REQ*8-1:0]       outstanding,
  output logic                     err_unexp_ack,
  output logic                     err_bad_id
);

  localparam int PW = $clog2(N_REQ);

  logic               sq_valid_r;
  logic [SQ_BITS-1:0] sq_data_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [7:0]         cnt_r     [N_REQ];
  logic [7:0]         cnt_nxt_s [N_REQ];
  logic [N_REQ-1:0]   cq_valid_r;
  logic [ACK_BITS-1:0] cq_data_r;
  logic               err_unexp_r;
  logic               err_bad_r;

  logic [N_REQ-1:0]   elig_s;
  logic               found_s;
  logic [PW-1:0]      win_s;
  logic               grant_s;
  logic [N_REQ-1:0]   sq_ready_s;
  logic [SQ_BITS-1:0] tagged_s;
  logic [ID_BITS-1:0] ack_id_s;
  logic               id_ok_s;
  logic               cq_deliver_s;
  logic               cq_ready_s;
  logic               cq_capture_s;
  logic               unexp_s;

  // Eligibility uses the registered credit count only.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = s_sq_valid[i] && (cnt_r[i] < 8'(MAX_OUT));
    end
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && elig_s[idx]) begin
        found_s = 1'b1;
        win_s   = PW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant, ready steering and descriptor tagging for the winner.
  always_comb begin
    grant_s    = !areset && found_s && (!sq_valid_r || m_sq_ready);
    sq_ready_s = '0;
    if (grant_s) begin
      sq_ready_s[win_s] = 1'b1;
    end else begin
      sq_ready_s = '0;
    end
    tagged_s = s_sq_data[win_s*SQ_BITS +: SQ_BITS];
    tagged_s[SQ_ID_LSB +: ID_BITS] = ID_BITS'(win_s);
  end

  // CQ handshake decode; out-of-range indices are recognised here and dropped.
  always_comb begin
    ack_id_s     = s_cq_data[ACK_ID_LSB +: ID_BITS];
    id_ok_s      = (32'(ack_id_s) < 32'(N_REQ));
    cq_deliver_s = |(cq_valid_r & m_cq_ready);
    cq_ready_s   = !areset && (!(|cq_valid_r) || cq_deliver_s);
    cq_capture_s = s_cq_valid && cq_ready_s;
  end

  // Credit next-state: an accept and a delivery in the same cycle cancel out.
  always_comb begin
    unexp_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      case ({grant_s && (win_s == PW'(i)), cq_valid_r[i] && m_cq_ready[i]})
        2'b10: cnt_nxt_s[i] = cnt_r[i] + 8'd1;
        2'b01: begin
          if (cnt_r[i] == 8'd0) begin
            unexp_s = 1'b1;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] - 8'd1;
          end
        end
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
    end
  end

  // SQ output register and round-robin pointer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sq_valid_r <= 1'b0;
      sq_data_r  <= '0;
      rr_ptr_r   <= PW'(N_REQ - 1);
    end else if (grant_s) begin
      sq_valid_r <= 1'b1;
      sq_data_r  <= tagged_s;
      rr_ptr_r   <= win_s;
    end else if (m_sq_ready) begin
      sq_valid_r <= 1'b0;
    end
  end

  // Credit counters and sticky unexpected-ack flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= 8'd0;
      end
      err_unexp_r <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      if (unexp_s) begin
        err_unexp_r <= 1'b1;
      end
    end
  end

  // CQ return register holding a one-hot target and the ack payload.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cq_valid_r <= '0;
      cq_data_r  <= '0;
      err_bad_r  <= 1'b0;
    end else if (cq_capture_s) begin
      cq_data_r <= s_cq_data;
      if (id_ok_s) begin
        cq_valid_r <= N_REQ'(1) << ack_id_s;
      end else begin
        cq_valid_r <= '0;
        err_bad_r  <= 1'b1;
      end
    end else if (cq_deliver_s) begin
      cq_valid_r <= '0;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_out
    assign outstanding[g*8 +: 8] = cnt_r[g];
  end

  assign s_sq_ready    = sq_ready_s;
  assign m_sq_valid    = sq_valid_r;
  assign m_sq_data     = sq_data_r;
  assign s_cq_ready    = cq_ready_s;
  assign m_cq_valid    = cq_valid_r;
  assign m_cq_data     = cq_data_r;
  assign err_unexp_ack = err_unexp_r;
  assign err_bad_id    = err_bad_r;

endmodule

// File: tb/tb_rdma_sq_arbiter.sv
// Scenario bench for rdma_sq_arbiter: expected SQ descriptors are queued at
// stimulus time and compared when the network side takes them.
module tb_rdma_sq_arbiter;

  localparam int N_REQ    = 4;
  localparam int SQ_BITS  = 32;
  localparam int ACK_BITS = 16;

  logic                     aclk = 1'b0;
  logic                     areset;
  logic [N_REQ-1:0]         s_sq_valid;
  logic [N_REQ-1:0]         s_sq_ready;
  logic [N_REQ*SQ_BITS-1:0] s_sq_data;
  logic                     m_sq_valid;
  logic                     m_sq_ready;
  logic [SQ_BITS-1:0]       m_sq_data;
  logic                     s_cq_valid;
  logic                     s_cq_ready;
  logic [ACK_BITS-1:0]      s_cq_data;
  logic [N_REQ-1:0]         m_cq_valid;
  logic [N_REQ-1:0]         m_cq_ready;
  logic [ACK_BITS-1:0]      m_cq_data;
  logic [N_REQ*8-1:0]       outstanding;
  logic                     err_unexp_ack;
  logic                     err_bad_id;

  int checks = 0;
  int errors = 0;
  logic [SQ_BITS-1:0] sb_q[$];

  rdma_sq_arbiter #(
    .N_REQ(N_REQ), .SQ_BITS(SQ_BITS), .ACK_BITS(ACK_BITS), .ID_BITS(4),
    .SQ_ID_LSB(0), .ACK_ID_LSB(0), .MAX_OUT(2)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
    .s_cq_valid(s_cq_valid), .s_cq_ready(s_cq_ready), .s_cq_data(s_cq_data),
    .m_cq_valid(m_cq_valid), .m_cq_ready(m_cq_ready), .m_cq_data(m_cq_data),
    .outstanding(outstanding), .err_unexp_ack(err_unexp_ack), .err_bad_id(err_bad_id)
  );

  always #5 aclk = ~aclk;

  function automatic logic [SQ_BITS-1:0] desc(input int i);
    desc = {8'hD0 + 8'(i), 8'h5C, 8'hAB, 4'h3, 4'hF};
  endfunction

  function automatic logic [SQ_BITS-1:0] tag(input int i);
    tag = {8'hD0 + 8'(i), 8'h5C, 8'hAB, 4'h3, 4'(i)};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    areset     = 1'b1;
    s_sq_valid = '0;
    m_sq_ready = 1'b0;
    s_cq_valid = 1'b0;
    s_cq_data  = '0;
    m_cq_ready = '0;
    sb_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  // Scoreboard: every SQ beat taken by the network side must match the queue head.
  always @(negedge aclk) begin
    if (!areset && m_sq_valid && m_sq_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sq_unexpected: got %h, required no beat", m_sq_data);
      end else begin
        logic [SQ_BITS-1:0] exp_d;
        exp_d = sb_q.pop_front();
        if (m_sq_data !== exp_d) begin
          errors++;
          $display("FAIL sq_data: got %h, required %h", m_sq_data, exp_d);
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    checks++;
    if ({s_sq_ready, s_cq_ready, m_sq_valid, m_cq_valid, outstanding, err_unexp_ack, err_bad_id} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b cqrdy=%b sqv=%b cqv=%b out=%h errs=%b%b, required all 0",
               s_sq_ready, s_cq_ready, m_sq_valid, m_cq_valid, outstanding, err_unexp_ack, err_bad_id);
    end
    @(posedge aclk);
    #1;
    areset     = 1'b0;
    s_sq_valid = '0;
    #1;
    checks++;
    if (s_cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cq_ready: got %b, required 1", s_cq_ready);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    m_sq_ready = 1'b1;
    s_sq_valid = 4'hF;
    for (int k = 0; k < 8; k++) sb_q.push_back(tag(k % 4));
    #1;
    checks++;
    if (s_sq_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first: got %b, required 0001", s_sq_ready);
    end
    repeat (10) tick();
    checks++;
    if (outstanding !== 32'h02020202 || s_sq_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rr_credits: got out=%h rdy=%b, required 02020202/0000", outstanding, s_sq_ready);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got %0d left, required 0", sb_q.size());
    end
    s_sq_valid = '0;
  endtask

  task automatic test_credit();
    int acc;
    do_reset();
    acc        = 0;
    m_sq_ready = 1'b1;
    s_sq_valid = 4'b0010;
    sb_q.push_back(tag(1));
    sb_q.push_back(tag(1));
    for (int k = 0; k < 6; k++) begin
      #1;
      if (s_sq_ready[1]) acc++;
      tick();
    end
    checks++;
    if (acc != 2 || outstanding[15:8] !== 8'd2 || s_sq_ready !== 4'b0000) begin
      errors++;
      $display("FAIL credit_limit: got acc=%0d out1=%0d rdy=%b, required 2/2/0000", acc, outstanding[15:8], s_sq_ready);
    end
    s_cq_valid = 1'b1;
    s_cq_data  = 16'hAC01;
    m_cq_ready = 4'b0010;
    #1;
    checks++;
    if (s_cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_cq_ready: got %b, required 1", s_cq_ready);
    end
    tick();
    s_cq_valid = 1'b0;
    #1;
    checks++;
    if (m_cq_valid !== 4'b0010 || m_cq_data !== 16'hAC01 || s_sq_ready !== 4'b0000) begin
      errors++;
      $display("FAIL credit_ack: got cqv=%b cqd=%h rdy=%b, required 0010/ac01/0000", m_cq_valid, m_cq_data, s_sq_ready);
    end
    tick();
    sb_q.push_back(tag(1));
    #1;
    checks++;
    if (s_sq_ready !== 4'b0010 || outstanding[15:8] !== 8'd1) begin
      errors++;
      $display("FAIL credit_regrant: got rdy=%b out1=%0d, required 0010/1", s_sq_ready, outstanding[15:8]);
    end
    tick();
    #1;
    checks++;
    if (s_sq_ready !== 4'b0000 || outstanding[15:8] !== 8'd2 || err_unexp_ack !== 1'b0) begin
      errors++;
      $display("FAIL credit_refill: got rdy=%b out1=%0d unexp=%b, required 0000/2/0", s_sq_ready, outstanding[15:8], err_unexp_ack);
    end
    s_sq_valid = '0;
    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL credit_drain: got %0d left, required 0", sb_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_sq_ready = 1'b0;
    s_sq_valid = 4'b0101;
    sb_q.push_back(tag(0));
    sb_q.push_back(tag(2));
    #1;
    checks++;
    if (s_sq_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first: got %b, required 0001", s_sq_ready);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (m_sq_valid !== 1'b1 || m_sq_data !== tag(0) || s_sq_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold: got v=%b d=%h rdy=%b, required 1/%h/0000", m_sq_valid, m_sq_data, s_sq_ready, tag(0));
      end
      tick();
    end
    m_sq_ready = 1'b1;
    #1;
    checks++;
    if (s_sq_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release: got %b, required 0100", s_sq_ready);
    end
    tick();
    s_sq_valid = '0;
    #1;
    checks++;
    if (m_sq_valid !== 1'b1 || m_sq_data !== tag(2)) begin
      errors++;
      $display("FAIL bp_next: got v=%b d=%h, required 1/%h", m_sq_valid, m_sq_data, tag(2));
    end
    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d left, required 0", sb_q.size());
    end
  endtask

  task automatic test_cq();
    do_reset();
    s_cq_valid = 1'b1;
    s_cq_data  = 16'h5A03;
    #1;
    checks++;
    if (s_cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL cq_ready_empty: got %b, required 1", s_cq_ready);
    end
    tick();
    s_cq_valid = 1'b0;
    #1;
    checks++;
    if (m_cq_valid !== 4'b1000 || m_cq_data !== 16'h5A03 || s_cq_ready !== 1'b0 || err_unexp_ack !== 1'b0) begin
      errors++;
      $display("FAIL cq_steer: got v=%b d=%h rdy=%b unexp=%b, required 1000/5a03/0/0", m_cq_valid, m_cq_data, s_cq_ready, err_unexp_ack);
    end
    tick();
    checks++;
    if (m_cq_valid !== 4'b1000 || m_cq_data !== 16'h5A03) begin
      errors++;
      $display("FAIL cq_hold: got v=%b d=%h, required 1000/5a03", m_cq_valid, m_cq_data);
    end
    m_cq_ready = 4'b1000;
    #1;
    checks++;
    if (s_cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL cq_ready_drain: got %b, required 1", s_cq_ready);
    end
    tick();
    #1;
    checks++;
    if (m_cq_valid !== 4'b0000 || err_unexp_ack !== 1'b1 || outstanding !== 32'h0) begin
      errors++;
      $display("FAIL cq_unexp: got v=%b unexp=%b out=%h, required 0000/1/0", m_cq_valid, err_unexp_ack, outstanding);
    end
    s_cq_valid = 1'b1;
    s_cq_data  = 16'h7709;
    tick();
    s_cq_valid = 1'b0;
    #1;
    checks++;
    if (m_cq_valid !== 4'b0000 || err_bad_id !== 1'b1 || s_cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL cq_bad_id: got v=%b bad=%b rdy=%b, required 0000/1/1", m_cq_valid, err_bad_id, s_cq_ready);
    end
    m_cq_ready = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_sq_ready = 1'b1;
    s_sq_valid = 4'b0001;
    sb_q.push_back(tag(0));
    tick();
    s_sq_valid = '0;
    s_cq_valid = 1'b1;
    s_cq_data  = 16'h0B00;
    m_cq_ready = 4'b0001;
    tick();
    s_cq_valid = 1'b0;
    s_sq_valid = 4'b0001;
    sb_q.push_back(tag(0));
    #1;
    checks++;
    if (s_sq_ready !== 4'b0001 || m_cq_valid !== 4'b0001 || outstanding[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL sim_setup: got rdy=%b cqv=%b out0=%0d, required 0001/0001/1", s_sq_ready, m_cq_valid, outstanding[7:0]);
    end
    tick();
    s_sq_valid = '0;
    #1;
    checks++;
    if (outstanding[7:0] !== 8'd1 || m_cq_valid !== 4'b0000 || m_sq_valid !== 1'b1 || err_unexp_ack !== 1'b0) begin
      errors++;
      $display("FAIL sim_both: got out0=%0d cqv=%b sqv=%b unexp=%b, required 1/0000/1/0", outstanding[7:0], m_cq_valid, m_sq_valid, err_unexp_ack);
    end
    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sim_drain: got %0d left, required 0", sb_q.size());
    end
    m_cq_ready = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m_sq_ready = 1'b1;
    s_sq_valid = 4'hF;
    s_cq_valid = 1'b1;
    s_cq_data  = 16'h000C;
    for (int k = 0; k < 3; k++) sb_q.push_back(tag(k));
    tick();
    s_cq_data = 16'h0002;
    tick();
    s_cq_valid = 1'b0;
    tick();
    checks++;
    if (err_bad_id !== 1'b1 || m_cq_valid !== 4'b0100 || m_sq_valid !== 1'b1 || outstanding === 32'h0) begin
      errors++;
      $display("FAIL mid_pre: got bad=%b cqv=%b sqv=%b out=%h, required 1/0100/1/nonzero", err_bad_id, m_cq_valid, m_sq_valid, outstanding);
    end
    #2;
    areset = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if ({s_sq_ready, s_cq_ready, m_sq_valid, m_cq_valid, outstanding, err_unexp_ack, err_bad_id} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b cqrdy=%b sqv=%b cqv=%b out=%h errs=%b%b, required all 0",
               s_sq_ready, s_cq_ready, m_sq_valid, m_cq_valid, outstanding, err_unexp_ack, err_bad_id);
    end
    areset = 1'b0;
    sb_q.push_back(tag(0));
    #1;
    checks++;
    if (s_sq_ready !== 4'b0001 || s_cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_regrant: got rdy=%b cqrdy=%b, required 0001/1", s_sq_ready, s_cq_ready);
    end
    tick();
    s_sq_valid = '0;
    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL mid_drain: got %0d left, required 0", sb_q.size());
    end
  endtask

  initial begin
    areset     = 1'b1;
    s_sq_valid = 4'hF;
    m_sq_ready = 1'b0;
    s_cq_valid = 1'b0;
    s_cq_data  = '0;
    m_cq_ready = '0;
    for (int i = 0; i < N_REQ; i++) s_sq_data[i*SQ_BITS +: SQ_BITS] = desc(i);
    test_reset();
    test_fairness();
    test_credit();
    test_backpressure();
    test_cq();
    test_simultaneous();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule

// File: doc/rdma_sq_arbiter.md
# rdma_sq_arbiter

Shares one RDMA send-queue (SQ) channel and its completion-queue (CQ) return path between N_REQ user requesters (vFPGA regions) ahead of the RDMA slice array. Requests are granted round-robin, tagged with the requester index, and registered onto the single network-side SQ. Each requester's in-flight requests are bounded by a credit counter. Returning CQ acks are steered back to the requester whose index they carry, which frees one credit.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16)
- SQ_BITS, 256, SQ descriptor width
- ACK_BITS, 32, CQ ack width
- ID_BITS, 4, requester index field width (≥ clog2(N_REQ))
- SQ_ID_LSB, 0, LSB of the index field in the SQ descriptor
- ACK_ID_LSB, 0, LSB of the index field in the CQ ack
- MAX_OUT, 16, max outstanding requests per requester (1..255)

Ports:
- aclk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- s_sq_valid  in  N_REQ  per-requester SQ valid
- s_sq_ready  out  N_REQ  per-requester SQ ready
- s_sq_data  in  N_REQ*SQ_BITS  per-requester descriptors, requester i at [i*SQ_BITS +: SQ_BITS]
- m_sq_valid / m_sq_ready / m_sq_data  out/in/out  1/1/SQ_BITS  network-side SQ
- s_cq_valid / s_cq_ready / s_cq_data  in/out/in  1/1/ACK_BITS  network-side CQ
- m_cq_valid  out  N_REQ  per-requester CQ valid
- m_cq_ready  in  N_REQ  per-requester CQ ready
- m_cq_data  out  ACK_BITS  ack, shared by all requesters
- outstanding  out  N_REQ*8  per-requester credit-in-use counts
- err_unexp_ack  out  1  sticky: an ack arrived for a requester with zero outstanding
- err_bad_id  out  1  sticky: an ack carried an index ≥ N_REQ

## Operation
- Eligibility: requester i is eligible when s_sq_valid[i]=1 and outstanding[i] < MAX_OUT.
- Round-robin grant:
  - rr_ptr holds the index of the last requester granted.
  - The search starts at rr_ptr+1 and wraps modulo N_REQ.
  - The first eligible requester wins.
  - rr_ptr updates only on an accepted transfer.
- SQ output register: one entry.
  - A grant is issued when the entry is empty, or when it is draining this cycle (m_sq_valid & m_sq_ready).
  - s_sq_ready is one-hot to the winner only in that case; otherwise all bits are 0.
  - The ready bits depend on s_sq_valid; a requester must not make valid wait on ready.
- Tagging: the register loads the winner's descriptor with bits [SQ_ID_LSB +: ID_BITS] overwritten by the winner index. All other bits pass unchanged.
- Credit counters:
  - outstanding[i] increments on an accept from requester i.
  - It decrements when an ack is delivered to requester i (m_cq_valid[i] & m_cq_ready[i]).
  - When both events occur in the same cycle the count is unchanged.
  - A decrement at 0 keeps the count at 0 and sets err_unexp_ack.
- CQ return register: one entry.
  - s_cq_ready = entry empty OR entry delivered this cycle.
  - On capture, the index is id = s_cq_data[ACK_ID_LSB +: ID_BITS].
  - If id < N_REQ: m_cq_valid is one-hot at id and m_cq_data is the captured ack.
  - If id ≥ N_REQ: the ack is dropped, no m_cq_valid bit is raised, no counter changes, and err_bad_id is set.
- Ordering: the CQ path is independent of the SQ path. Both may transfer in the same cycle.

## Timing
- Reset (areset=1, asynchronous) drives:
  - m_sq_valid=0, s_sq_ready=0
  - m_cq_valid=0, s_cq_ready=0
  - all outstanding=0, rr_ptr=N_REQ-1
  - both error flags=0
- While areset=1 all readies are 0. In the first cycle after release, s_cq_ready=1 and any eligible requester can be granted.
- Reset mid-operation: in-flight register contents and credits are discarded. No output glitches to a stale valid.
- SQ latency: accept in cycle t gives m_sq_valid=1 in cycle t+1. Throughput is one descriptor per cycle under continuous m_sq_ready.
- CQ latency: capture in cycle t gives m_cq_valid in cycle t+1. Throughput is one ack per cycle when the target requester's ready is held high.
- Backpressure:
  - m_sq_valid and m_sq_data stay stable until m_sq_ready.
  - m_cq_valid and m_cq_data stay stable until the target's m_cq_ready; a stalled target blocks all CQ traffic (head-of-line).
- A counter at MAX_OUT with a same-cycle delivery is still ineligible in that cycle, because eligibility uses the registered count. It is eligible in the next cycle.

## Test plan
- Round-robin fairness: N_REQ=4, all valid, m_sq_ready=1 for 8 cycles -> m_sq_data ID field reads 0,1,2,3,0,1,2,3, and each accepted descriptor is otherwise unchanged.
- Credit limit: MAX_OUT=2, requester 1 alone valid, no acks -> exactly 2 accepts, then s_sq_ready[1]=0 and outstanding[1]=2. Inject an ack with id=1 and m_cq_ready[1]=1 -> one more accept follows two cycles after the ack is captured.
- Backpressure: m_sq_ready=0 for 5 cycles with requesters 0 and 2 valid -> one descriptor (requester 0) is held stable and no further s_sq_ready is asserted. Release -> the requester 2 descriptor appears in the next cycle.
- CQ steering and errors:
  - ack id=3 -> m_cq_valid=4'b1000.
  - ack id=3 with outstanding[3]=0 -> delivered and err_unexp_ack=1.
  - ack id=9 with N_REQ=4 -> no m_cq_valid, err_bad_id=1, s_cq_ready stays 1.
- Simultaneous events: in one cycle, requester 0 is accepted and an ack for requester 0 is delivered -> outstanding[0] is unchanged. Both paths each transfer one beat.
- Async reset mid-burst: assert areset between clock edges -> all valids, readies, counters and flags are 0 immediately. After release the first grant goes to requester 0.
